// File: rtl/out_stream_ctrl_pkg.sv
// rtl/out_stream_ctrl_pkg.sv - shared types and width helpers for the output stream controller
package out_ctrl_pkg;

   typedef enum logic [2:0] {
      SCAN_HI,
      SCAN_LO,
      CHK,
      REQ,
      STROBE,
      LATCH,
      HOLD,
      GAP
   } state_t;

   localparam logic [7:0] TIMEOUT_MAX = 8'hFF;

   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int hold_width(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/out_stream_ctrl_if.sv
// rtl/out_stream_ctrl_if.sv - FIFO-side and host-side signals of the output stream controller
interface out_stream_ctrl_if
   import out_ctrl_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int DATA_W  = 11,
   parameter int LEVEL_W = 4,
   parameter int CH_W    = ch_width(NUM_CH)
);
   logic [NUM_CH*DATA_W-1:0]  data_in;
   logic [NUM_CH*LEVEL_W-1:0] avaliable_data;
   logic                      irq_ack;
   logic                      fifo_read_clock;
   logic [NUM_CH-1:0]         fifo_read_irq;
   logic [DATA_W-1:0]         data_out;
   logic [CH_W-1:0]           ch_out;
   logic                      IRQ;
   logic [7:0]                timeout_cnt;

   modport master (
      input  data_in, avaliable_data, irq_ack,
      output fifo_read_clock, fifo_read_irq, data_out, ch_out, IRQ, timeout_cnt
   );

   modport slave (
      output data_in, avaliable_data, irq_ack,
      input  fifo_read_clock, fifo_read_irq, data_out, ch_out, IRQ, timeout_cnt
   );
endinterface

// File: rtl/out_stream_ctrl_irq_pulse_timer.sv
// rtl/out_stream_ctrl_irq_pulse_timer.sv - IRQ high/low timing, acknowledge and timeout counting
module irq_pulse_timer
   import out_ctrl_pkg::*;
#(
   parameter int IRQ_LEN  = 247,
   parameter int MIN_GAP  = 2,
   parameter int ACK_MODE = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       hold_active,
   input  logic       gap_active,
   input  logic       irq_ack,
   output logic       hold_end,
   output logic       gap_end,
   output logic       irq,
   output logic [7:0] timeout_cnt
);
   localparam int HOLD_W = hold_width(IRQ_LEN);
   localparam int GAP_W  = hold_width(MIN_GAP);
   localparam logic [HOLD_W-1:0] LEN_C    = HOLD_W'(IRQ_LEN);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(MIN_GAP - 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              expired;
   logic              acked;

   always_comb begin
      expired  = (hold_cnt == LEN_C);
      acked    = (ACK_MODE != 0) && irq_ack;
      hold_end = hold_active && (expired || acked);
      gap_end  = gap_active && (gap_cnt == GAP_LAST);
   end

   // An ack on the very cycle the length expires still counts as acknowledged.
   always_ff @(posedge clock) begin
      if (reset) begin
         irq         <= 1'b0;
         hold_cnt    <= '0;
         gap_cnt     <= '0;
         timeout_cnt <= '0;
      end else if (start) begin
         irq      <= 1'b1;
         hold_cnt <= HOLD_W'(1);
      end else if (hold_active) begin
         if (hold_end) begin
            irq     <= 1'b0;
            gap_cnt <= '0;
            if ((ACK_MODE != 0) && expired && !acked && (timeout_cnt != TIMEOUT_MAX))
               timeout_cnt <= timeout_cnt + 8'd1;
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end else if (gap_active) begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/out_stream_ctrl.sv
// rtl/out_stream_ctrl.sv - round-robin multi-FIFO reader that hands words to the host with an IRQ
module out_stream_ctrl
   import out_ctrl_pkg::*;
#(
   parameter int DATA_W   = 11,
   parameter int LEVEL_W  = 4,
   parameter int NUM_CH   = 2,
   parameter int IRQ_LEN  = 247,
   parameter int MIN_GAP  = 2,
   parameter int ACK_MODE = 0
) (
   input logic              clock,
   input logic              reset,
   out_stream_ctrl_if.master bus
);
   localparam int CH_W = ch_width(NUM_CH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   state_t            state;
   logic [CH_W-1:0]   ptr;
   logic [CH_W-1:0]   sel;
   logic [LEVEL_W-1:0] cur_level;
   logic [DATA_W-1:0] sel_data;
   logic              start;
   logic              hold_active;
   logic              gap_active;
   logic              hold_end;
   logic              gap_end;

   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
      return (c == LAST_CH) ? '0 : c + 1'b1;
   endfunction

   function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] c);
      return NUM_CH'(1) << c;
   endfunction

   always_comb begin
      cur_level   = bus.avaliable_data[int'(ptr)*LEVEL_W +: LEVEL_W];
      sel_data    = bus.data_in[int'(sel)*DATA_W +: DATA_W];
      start       = (state == LATCH);
      hold_active = (state == HOLD);
      gap_active  = (state == GAP);
   end

   // Outputs are registered on entry to each state so they are clean for the whole state cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= SCAN_HI;
         ptr                 <= '0;
         sel                 <= '0;
         bus.fifo_read_clock <= 1'b0;
         bus.fifo_read_irq   <= '0;
         bus.data_out        <= '0;
         bus.ch_out          <= '0;
      end else begin
         case (state)
            SCAN_HI: begin
               bus.fifo_read_clock <= 1'b0;
               state               <= SCAN_LO;
            end
            SCAN_LO: state <= CHK;
            CHK: begin
               if (cur_level != '0) begin
                  sel               <= ptr;
                  bus.fifo_read_irq <= onehot(ptr);
                  state             <= REQ;
               end else begin
                  ptr                 <= next_ch(ptr);
                  bus.fifo_read_clock <= 1'b1;
                  state               <= SCAN_HI;
               end
            end
            REQ: begin
               bus.fifo_read_clock <= 1'b1;
               state               <= STROBE;
            end
            STROBE: begin
               bus.fifo_read_clock <= 1'b0;
               bus.fifo_read_irq   <= '0;
               state               <= LATCH;
            end
            LATCH: begin
               bus.data_out <= sel_data;
               bus.ch_out   <= sel;
               state        <= HOLD;
            end
            HOLD: if (hold_end) state <= GAP;
            GAP: begin
               if (gap_end) begin
                  ptr                 <= next_ch(sel);
                  bus.fifo_read_clock <= 1'b1;
                  state               <= SCAN_HI;
               end
            end
            default: state <= SCAN_HI;
         endcase
      end
   end

   irq_pulse_timer #(
      .IRQ_LEN  (IRQ_LEN),
      .MIN_GAP  (MIN_GAP),
      .ACK_MODE (ACK_MODE)
   ) u_timer (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .hold_active (hold_active),
      .gap_active  (gap_active),
      .irq_ack     (bus.irq_ack),
      .hold_end    (hold_end),
      .gap_end     (gap_end),
      .irq         (bus.IRQ),
      .timeout_cnt (bus.timeout_cnt)
   );
endmodule

// File: tb/tb_out_stream_ctrl.sv
// tb/tb_out_stream_ctrl.sv - self-checking bench for out_stream_ctrl in fixed-length and acknowledge modes
module tb_out_stream_ctrl;
   import out_ctrl_pkg::*;

   localparam int DW   = 11;
   localparam int LW   = 4;
   localparam int N0   = 2;
   localparam int LEN0 = 247;
   localparam int GAP0 = 2;
   localparam int N1   = 3;
   localparam int LEN1 = 20;
   localparam int GAP1 = 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   out_stream_ctrl_if #(.NUM_CH(N0), .DATA_W(DW), .LEVEL_W(LW)) bus0 ();
   out_stream_ctrl_if #(.NUM_CH(N1), .DATA_W(DW), .LEVEL_W(LW)) bus1 ();

   out_stream_ctrl #(
      .DATA_W(DW), .LEVEL_W(LW), .NUM_CH(N0), .IRQ_LEN(LEN0), .MIN_GAP(GAP0), .ACK_MODE(0)
   ) dut0 (.clock(clock), .reset(reset), .bus(bus0));

   out_stream_ctrl #(
      .DATA_W(DW), .LEVEL_W(LW), .NUM_CH(N1), .IRQ_LEN(LEN1), .MIN_GAP(GAP1), .ACK_MODE(1)
   ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

   int tests = 0;
   int fails = 0;
   int lv0[16], dv0[16], lv1[16], dv1[16];
   int p0, p1, tmo_model;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int first_ch(input int p, input int n, input int lv[16], output int skips);
      for (int s = 0; s < n; s++) begin
         if (lv[(p + s) % n] != 0) begin
            skips = s;
            return (p + s) % n;
         end
      end
      skips = n;
      return 0;
   endfunction

   task automatic rand_fill(input int n, output int lv[16], output int dv[16]);
      bit any = 0;
      for (int k = 0; k < 16; k++) begin
         lv[k] = 0;
         dv[k] = 0;
      end
      for (int k = 0; k < n; k++) begin
         lv[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
         dv[k] = int'($urandom & 32'h7FF);
         if (lv[k] != 0) any = 1;
      end
      if (!any) lv[$urandom_range(0, n - 1)] = int'($urandom_range(1, 15));
   endtask

   task automatic drive0();
      for (int k = 0; k < N0; k++) begin
         bus0.avaliable_data[k*LW +: LW] = LW'(lv0[k]);
         bus0.data_in[k*DW +: DW]        = DW'(dv0[k]);
      end
   endtask

   task automatic drive1();
      for (int k = 0; k < N1; k++) begin
         bus1.avaliable_data[k*LW +: LW] = LW'(lv1[k]);
         bus1.data_in[k*DW +: DW]        = DW'(dv1[k]);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rst_irq0", bus0.IRQ, 0);
      check("rst_req0", bus0.fifo_read_irq, 0);
      check("rst_data0", bus0.data_out, 0);
      check("rst_ch0", bus0.ch_out, 0);
      check("rst_rclk0", bus0.fifo_read_clock, 0);
      check("rst_irq1", bus1.IRQ, 0);
      check("rst_tmo1", bus1.timeout_cnt, 0);
      reset     = 1'b0;
      p0        = 0;
      p1        = 0;
      tmo_model = 0;
   endtask

   // One IRQ-high stretch followed by the IRQ-low stretch up to the next rise.
   task automatic ep0(output int h, output int l, output int reqs, output logic [N0-1:0] rv,
                      output int d, output int ch);
      h = 0; l = 0; reqs = 0; rv = '0;
      while (bus0.IRQ === 1'b1 && h < 2000) begin
         h++;
         @(negedge clock);
      end
      while (bus0.IRQ !== 1'b1 && l < 2000) begin
         l++;
         if (bus0.fifo_read_irq != '0) begin
            reqs++;
            rv = rv | bus0.fifo_read_irq;
         end
         @(negedge clock);
      end
      d  = int'(bus0.data_out);
      ch = int'(bus0.ch_out);
   endtask

   task automatic ep1(input int j, input bit ack_low, output int h, output int l, output int reqs,
                      output logic [N1-1:0] rv, output int d, output int ch, output int tmo);
      h = 0; l = 0; reqs = 0; rv = '0;
      while (bus1.IRQ === 1'b1 && h < 2000) begin
         h++;
         bus1.irq_ack = (h == j);
         @(negedge clock);
      end
      bus1.irq_ack = ack_low;
      tmo = int'(bus1.timeout_cnt);
      while (bus1.IRQ !== 1'b1 && l < 2000) begin
         l++;
         if (bus1.fifo_read_irq != '0) begin
            reqs++;
            rv = rv | bus1.fifo_read_irq;
         end
         @(negedge clock);
      end
      bus1.irq_ack = 1'b0;
      d  = int'(bus1.data_out);
      ch = int'(bus1.ch_out);
   endtask

   task automatic run0(input bit fresh);
      int k, s, h, l, reqs, d, ch;
      logic [N0-1:0] rv;
      k = first_ch(p0, N0, lv0, s);
      ep0(h, l, reqs, rv, d, ch);
      check("irq_len0", h, fresh ? 0 : LEN0);
      check("low_len0", l, (fresh ? 0 : GAP0) + 6 + 3 * s);
      check("req_cycles0", reqs, 2);
      check("req_bits0", rv, 64'd1 << k);
      check("data0", d, dv0[k]);
      check("ch0", ch, k);
      check("tmo0", bus0.timeout_cnt, 0);
      p0 = (k + 1) % N0;
   endtask

   task automatic run1(input int j, input bit ack_low, input bit fresh);
      int k, s, h, l, reqs, d, ch, tmo, exp_h;
      logic [N1-1:0] rv;
      k = first_ch(p1, N1, lv1, s);
      ep1(j, ack_low, h, l, reqs, rv, d, ch, tmo);
      exp_h = 0;
      if (!fresh) begin
         if (j >= 1 && j <= LEN1) exp_h = j;
         else begin
            exp_h = LEN1;
            tmo_model++;
         end
      end
      check("irq_len1", h, exp_h);
      check("tmo1", tmo, (tmo_model > 255) ? 255 : tmo_model);
      check("low_len1", l, (fresh ? 0 : GAP1) + 6 + 3 * s);
      check("req_cycles1", reqs, 2);
      check("req_bits1", rv, 64'd1 << k);
      check("data1", d, dv1[k]);
      check("ch1", ch, k);
      p1 = (k + 1) % N1;
   endtask

   initial begin
      reset = 1'b1;
      bus0.irq_ack = 1'b0; bus0.data_in = '0; bus0.avaliable_data = '0;
      bus1.irq_ack = 1'b0; bus1.data_in = '0; bus1.avaliable_data = '0;
      for (int k = 0; k < 16; k++) begin
         lv0[k] = 0; dv0[k] = 0; lv1[k] = 0; dv1[k] = 0;
      end
      repeat (2) @(negedge clock);
      do_reset();

      // Idle scan: clock high one cycle in three, reset cycle excepted.
      for (int k = 0; k < 30; k++) begin
         check("idle_rclk", bus0.fifo_read_clock, (k > 0) && (k % 3 == 0));
         check("idle_req", bus0.fifo_read_irq, 0);
         check("idle_irq", bus0.IRQ, 0);
         @(negedge clock);
      end

      lv0[0] = 0; dv0[0] = 'h123;
      lv0[1] = 3; dv0[1] = 'h5A5;
      drive0();
      do_reset();
      run0(1);
      run0(0);

      for (int e = 0; e < 10; e++) begin
         if (e < 4) begin
            lv0[0] = 15; lv0[1] = 15;
            dv0[0] = int'($urandom & 32'h7FF);
            dv0[1] = int'($urandom & 32'h7FF);
         end else begin
            rand_fill(N0, lv0, dv0);
         end
         drive0();
         run0(0);
      end

      lv0[0] = 15; lv0[1] = 15;
      drive0();
      repeat (5) @(negedge clock);
      do_reset();
      run0(1);

      lv1[0] = 0; lv1[1] = 0; lv1[2] = 7;
      dv1[0] = 'h111; dv1[1] = 'h222; dv1[2] = 'h3C3;
      drive1();
      do_reset();
      run1(0, 0, 1);
      run1(11, 0, 0);
      run1(LEN1, 0, 0);
      run1(5, 1, 0);
      run1(0, 0, 0);

      for (int e = 0; e < 20; e++) begin
         rand_fill(N1, lv1, dv1);
         drive1();
         run1(int'($urandom_range(1, LEN1 + 6)), 1'($urandom_range(0, 1)), 0);
      end

      for (int e = 0; e < 300; e++) begin
         rand_fill(N1, lv1, dv1);
         drive1();
         run1(0, 0, 0);
      end
      check("tmo_saturated", bus1.timeout_cnt, 255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/out_stream_ctrl.md
Name: out_stream_ctrl

Overview:
- Multi-channel successor to the single-FIFO output controller.
- Scans NUM_CH FIFOs round-robin and issues a read-clock/read-request sequence to the first non-empty channel.
- Registers the word with its channel tag and raises IRQ to the host for a programmable length.
- Optional acknowledge mode ends IRQ early; a saturating counter records IRQs that timed out unacknowledged.

Parameters:
- DATA_W, 11, width of one FIFO word.
- LEVEL_W, 4, width of each FIFO fill-level input.
- NUM_CH, 2, number of FIFO channels (1..16).
- IRQ_LEN, 247, maximum IRQ high time in cycles (>=2).
- MIN_GAP, 2, minimum IRQ-low cycles before the next scan (>=1).
- ACK_MODE, 0, 0 = fixed-length IRQ; 1 = IRQ ends on irq_ack or at IRQ_LEN timeout.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  NUM_CH*DATA_W  FIFO read data; channel k at bits [k*DATA_W +: DATA_W].
- avaliable_data  in  NUM_CH*LEVEL_W  FIFO fill levels; channel k at [k*LEVEL_W +: LEVEL_W].
- irq_ack  in  1  host acknowledge; used only when ACK_MODE=1.
- fifo_read_clock  out  1  shared FIFO read clock, generated as register pulses.
- fifo_read_irq  out  NUM_CH  one-hot read request, one bit per channel.
- data_out  out  DATA_W  registered captured word.
- ch_out  out  max(1,$clog2(NUM_CH))  channel of data_out.
- IRQ  out  1  host interrupt.
- timeout_cnt  out  8  saturating count of unacknowledged IRQ timeouts (ACK_MODE=1 only).

Behaviour:
- Reset: all outputs 0; ptr=0; state=SCAN_HI; counters 0. Reset wins over every other event, including mid-IRQ or mid-read; there is no partial-read recovery.
- States, each lasting one cycle unless stated:
  - SCAN_HI: fifo_read_clock=1 -> SCAN_LO.
  - SCAN_LO: fifo_read_clock=0 -> CHK.
  - CHK: if level[ptr]!=0 latch sel=ptr -> REQ; else ptr=ptr+1 mod NUM_CH -> SCAN_HI.
  - REQ: fifo_read_irq[sel]=1, clock low -> STROBE.
  - STROBE: fifo_read_clock=1, request held -> LATCH.
  - LATCH: fifo_read_clock=0, fifo_read_irq=0; data_out<=data_in[sel], ch_out<=sel, IRQ<=1, hold counter<=1 -> HOLD.
  - HOLD: counter increments each cycle; IRQ<=0 -> GAP when either:
    - the counter reaches IRQ_LEN, or
    - ACK_MODE=1 and irq_ack=1.
  - GAP: MIN_GAP cycles with IRQ low; ptr<=sel+1 mod NUM_CH -> SCAN_HI.
- Timing:
  - IRQ rises 3 cycles after the CHK cycle that found data.
  - ACK_MODE=0: IRQ high exactly IRQ_LEN cycles.
  - ACK_MODE=1: IRQ falls on the edge after irq_ack is sampled high in HOLD.
- irq_ack is ignored outside HOLD, including during the LATCH cycle.
- Timeout: in ACK_MODE=1, reaching IRQ_LEN without an ack increments timeout_cnt, saturating at 255. timeout_cnt stays 0 in ACK_MODE=0.
- At most one fifo_read_irq bit is ever high, and only during REQ and STROBE. The clock never rises while a request is changing.
- Fairness: after servicing channel k, scanning resumes at k+1, so a permanently full channel cannot starve the others.
- NUM_CH=1: ptr and ch_out are constant 0.
- A level dropping to 0 between CHK and STROBE does not abort the read; the FIFO must ignore empty reads, and whatever is on data_in is captured.
- data_out and ch_out hold their value until the next LATCH.

Decomposition:
- Shared package out_ctrl_pkg holds:
  - state enum: SCAN_HI, SCAN_LO, CHK, REQ, STROBE, LATCH, HOLD, GAP;
  - localparam functions for the ch_out and hold-counter widths, $clog2(IRQ_LEN+1).
- One sub-module, irq_pulse_timer, covers the HOLD/GAP counting, ack handling and timeout_cnt saturation. The FSM and channel mux stay in the top level.

Test Plan:
- Reset mid-HOLD with NUM_CH=2 -> on the next edge IRQ=0, fifo_read_irq=0, data_out=0, and scanning restarts at channel 0.
- Channel 1 level=3, data_in[1]=0x5A5, channel 0 empty -> fifo_read_irq=2'b10 for 2 cycles, data_out=0x5A5, ch_out=1, IRQ high 247 cycles.
- Both channels level=15 continuously -> serviced order 0,1,0,1; the gap between IRQ falls and the next IRQ rise is constant.
- ACK_MODE=1, irq_ack asserted 10 cycles after IRQ rises -> IRQ falls on the following edge; timeout_cnt unchanged.
- ACK_MODE=1, no ack for 300 IRQs -> each IRQ lasts IRQ_LEN cycles; timeout_cnt saturates at 255.
- All levels 0 -> fifo_read_clock toggles with period 3 cycles (high 1 cycle); fifo_read_irq and IRQ stay 0.
